// File: rtl/coin_acceptor.sv
// Coin acceptor: turns coin-slot edges and player buttons into one committed
// credit amount (money/set) or a refund (refund/refund_valid).
module coin_acceptor #(
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned MAX_PENDING = 999,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned VAL_A       = 1,
  parameter int unsigned VAL_B       = 5,
  parameter int unsigned VAL_C       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_a,
  input  logic             coin_b,
  input  logic             coin_c,
  input  logic             confirm,
  input  logic             cancel,
  output logic [WIDTH-1:0] money,
  output logic             set,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] refund,
  output logic             refund_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned SUM_W = WIDTH + 2;
  localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;
  localparam logic [1:0] REFUND  = 2'd3;

  logic [1:0]       state, state_d;
  logic [TMR_W-1:0] timer, timer_d;
  logic             hist_a, hist_b, hist_c;
  logic [WIDTH-1:0] money_d, pending_d, refund_d;
  logic             set_d, refund_valid_d, overflow_d, busy_d;

  logic             edge_a, edge_b, edge_c, coin_in, clip;
  logic [SUM_W-1:0] inc, base, sum;
  logic [WIDTH-1:0] sat;

  // Rising-edge detection and saturating add of this cycle's coin value
  assign edge_a  = coin_a & ~hist_a;
  assign edge_b  = coin_b & ~hist_b;
  assign edge_c  = coin_c & ~hist_c;
  assign inc     = (edge_a ? SUM_W'(VAL_A) : '0)
                 + (edge_b ? SUM_W'(VAL_B) : '0)
                 + (edge_c ? SUM_W'(VAL_C) : '0);
  assign coin_in = (inc != '0);
  // Only COLLECT accumulates; every other state starts a fresh balance
  assign base    = (state == COLLECT) ? SUM_W'(pending) : '0;
  assign sum     = base + inc;
  assign clip    = (sum > SUM_W'(MAX_PENDING));
  assign sat     = clip ? WIDTH'(MAX_PENDING) : sum[WIDTH-1:0];

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state;
    timer_d        = timer;
    money_d        = money;
    pending_d      = pending;
    refund_d       = refund;
    set_d          = 1'b0;
    refund_valid_d = 1'b0;
    overflow_d     = overflow;

    case (state)
      IDLE: begin
        if (coin_in) begin
          pending_d  = sat;
          overflow_d = clip;
          timer_d    = '0;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (coin_in) begin
          pending_d = sat;
          if (clip) overflow_d = 1'b1;
        end
        // Strobes rise together with the COMMIT/REFUND state
        if (cancel) begin
          state_d        = REFUND;
          refund_d       = pending_d;
          refund_valid_d = 1'b1;
          overflow_d     = 1'b0;
        end else if (confirm) begin
          state_d    = COMMIT;
          money_d    = pending_d;
          set_d      = 1'b1;
          overflow_d = 1'b0;
        end else if (coin_in) begin
          timer_d = '0;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          state_d    = COMMIT;
          money_d    = pending;
          set_d      = 1'b1;
          overflow_d = 1'b0;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      COMMIT, REFUND: begin
        // Coins arriving now open a new session, never merged into the old one
        if (coin_in) begin
          pending_d  = sat;
          overflow_d = clip;
          timer_d    = '0;
          state_d    = COLLECT;
        end else begin
          pending_d = '0;
          timer_d   = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      hist_a       <= 1'b1;
      hist_b       <= 1'b1;
      hist_c       <= 1'b1;
      money        <= '0;
      set          <= 1'b0;
      pending      <= '0;
      refund       <= '0;
      refund_valid <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      timer        <= timer_d;
      hist_a       <= coin_a;
      hist_b       <= coin_b;
      hist_c       <= coin_c;
      money        <= money_d;
      set          <= set_d;
      pending      <= pending_d;
      refund       <= refund_d;
      refund_valid <= refund_valid_d;
      overflow     <= overflow_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: two instances (default and small limits) share one
// stimulus stream and are checked against a session-level reference model.
module tb_coin_acceptor;

  localparam int MAXP [2] = '{999, 20};
  localparam int TMO  [2] = '{1000, 8};

  logic clk, rst;
  logic coin_a, coin_b, coin_c, confirm, cancel;

  logic [9:0] d0_money, d0_pending, d0_refund;
  logic       d0_set, d0_rv, d0_ovf, d0_busy;
  logic [9:0] d1_money, d1_pending, d1_refund;
  logic       d1_set, d1_rv, d1_ovf, d1_busy;
  logic [33:0] obs0, obs1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one entry per instance
  int m_pend [2], m_idle [2], m_money [2], m_refund [2];
  bit m_act [2], m_closing [2], m_set [2], m_rv [2], m_ovf [2];
  bit m_ha, m_hb, m_hc;

  coin_acceptor u_dut0 (
    .clk(clk), .rst(rst), .coin_a(coin_a), .coin_b(coin_b), .coin_c(coin_c),
    .confirm(confirm), .cancel(cancel), .money(d0_money), .set(d0_set),
    .pending(d0_pending), .refund(d0_refund), .refund_valid(d0_rv),
    .overflow(d0_ovf), .busy(d0_busy)
  );

  coin_acceptor #(.MAX_PENDING(20), .TIMEOUT(8)) u_dut1 (
    .clk(clk), .rst(rst), .coin_a(coin_a), .coin_b(coin_b), .coin_c(coin_c),
    .confirm(confirm), .cancel(cancel), .money(d1_money), .set(d1_set),
    .pending(d1_pending), .refund(d1_refund), .refund_valid(d1_rv),
    .overflow(d1_ovf), .busy(d1_busy)
  );

  assign obs0 = {d0_money, d0_set, d0_pending, d0_refund, d0_rv, d0_ovf, d0_busy};
  assign obs1 = {d1_money, d1_set, d1_pending, d1_refund, d1_rv, d1_ovf, d1_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] exp_vec(int i);
    return {10'(m_money[i]), m_set[i], 10'(m_pend[i]), 10'(m_refund[i]),
            m_rv[i], m_ovf[i], m_act[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_idle[i] = 0; m_money[i] = 0; m_refund[i] = 0;
      m_act[i] = 0; m_closing[i] = 0; m_set[i] = 0; m_rv[i] = 0; m_ovf[i] = 0;
    end
    m_ha = 1; m_hb = 1; m_hc = 1;
  endtask

  // One clock of the session rules: coins add (clipped), cancel beats confirm,
  // idle time runs out after TMO cycles, strobes appear when the session closes.
  task automatic model_step(int i, int inc);
    int s;
    m_set[i] = 0;
    m_rv[i]  = 0;
    if (m_closing[i]) begin
      m_closing[i] = 0;
      if (inc > 0) begin
        m_pend[i] = (inc > MAXP[i]) ? MAXP[i] : inc;
        m_idle[i] = 0;
      end else begin
        m_pend[i] = 0;
        m_act[i]  = 0;
      end
    end else if (m_act[i]) begin
      if (inc > 0) begin
        s = m_pend[i] + inc;
        if (s > MAXP[i]) begin m_ovf[i] = 1; s = MAXP[i]; end
        m_pend[i] = s;
      end
      if (cancel) begin
        m_refund[i] = m_pend[i]; m_rv[i] = 1; m_ovf[i] = 0; m_closing[i] = 1;
      end else if (confirm) begin
        m_money[i] = m_pend[i]; m_set[i] = 1; m_ovf[i] = 0; m_closing[i] = 1;
      end else if (inc > 0) begin
        m_idle[i] = 0;
      end else if (m_idle[i] == TMO[i] - 1) begin
        m_money[i] = m_pend[i]; m_set[i] = 1; m_ovf[i] = 0; m_closing[i] = 1;
      end else begin
        m_idle[i]++;
      end
    end else if (inc > 0) begin
      m_pend[i] = (inc > MAXP[i]) ? MAXP[i] : inc;
      m_ovf[i]  = (inc > MAXP[i]);
      m_act[i]  = 1;
      m_idle[i] = 0;
    end
  endtask

  task automatic tick();
    int inc;
    if (rst) begin
      model_reset();
    end else begin
      inc = ((coin_a && !m_ha) ? 1 : 0) + ((coin_b && !m_hb) ? 5 : 0)
          + ((coin_c && !m_hc) ? 10 : 0);
      m_ha = coin_a; m_hb = coin_b; m_hc = coin_c;
      for (int i = 0; i < 2; i++) model_step(i, inc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    coin_a = 0; coin_b = 0; coin_c = 0; confirm = 0; cancel = 0;
    rst = 1;
    #2;
    model_reset();
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if (obs0 !== 34'h0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", obs0); end
    tick();
    rst = 0;
    repeat (3) tick();
    n_checks++;
    if (d0_pending !== 10'd0 || d0_busy !== 1'b0) begin
      n_fail++; $display("FAIL held_coin_ignored: pending=%0d busy=%0d expected 0 0", d0_pending, d0_busy);
    end
    coin_a = 0; tick();
    coin_a = 1; repeat (3) tick();
    coin_a = 0; tick();
    n_checks++;
    if (d0_pending !== 10'd1 || d0_busy !== 1'b1) begin
      n_fail++; $display("FAIL single_count: pending=%0d busy=%0d expected 1 1", d0_pending, d0_busy);
    end
    n_checks++;
    if (obs0 !== exp_vec(0)) begin n_fail++; $display("FAIL reset_model: got %h expected %h", obs0, exp_vec(0)); end
  endtask

  task automatic test_confirm();
    do_reset();
    coin_b = 1; tick(); coin_b = 0; tick();
    coin_c = 1; tick(); coin_c = 0; tick();
    coin_c = 1; tick(); coin_c = 0; tick();
    n_checks++;
    if (d0_pending !== 10'd25) begin n_fail++; $display("FAIL pending_25: got %0d expected 25", d0_pending); end
    confirm = 1; tick(); confirm = 0;
    n_checks++;
    if (d0_set !== 1'b1 || d0_money !== 10'd25) begin
      n_fail++; $display("FAIL commit_strobe: set=%0d money=%0d expected 1 25", d0_set, d0_money);
    end
    tick();
    n_checks++;
    if (d0_set !== 1'b0 || d0_pending !== 10'd0 || d0_busy !== 1'b0 || d0_money !== 10'd25) begin
      n_fail++; $display("FAIL after_commit: set=%0d pending=%0d busy=%0d money=%0d expected 0 0 0 25",
                         d0_set, d0_pending, d0_busy, d0_money);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    coin_a = 1; coin_b = 1; coin_c = 1; tick();
    coin_a = 0; coin_b = 0; coin_c = 0; tick();
    n_checks++;
    if (d0_pending !== 10'd16) begin n_fail++; $display("FAIL sum_16: got %0d expected 16", d0_pending); end
    confirm = 1; cancel = 1; tick(); confirm = 0; cancel = 0;
    n_checks++;
    if (d0_rv !== 1'b1 || d0_refund !== 10'd16 || d0_set !== 1'b0) begin
      n_fail++; $display("FAIL cancel_priority: rv=%0d refund=%0d set=%0d expected 1 16 0", d0_rv, d0_refund, d0_set);
    end
    tick();
    n_checks++;
    if (d0_rv !== 1'b0 || d0_set !== 1'b0) begin
      n_fail++; $display("FAIL refund_one_cycle: rv=%0d set=%0d expected 0 0", d0_rv, d0_set);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    coin_b = 1; tick(); coin_b = 0;
    n = 0;
    while (d1_set !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++;
    if (n != 8 || d1_money !== 10'd5) begin
      n_fail++; $display("FAIL timeout_commit: cycles=%0d money=%0d expected 8 5", n, d1_money);
    end
    tick();
    coin_b = 1; tick(); coin_b = 0;
    repeat (4) tick();
    coin_a = 1; tick(); coin_a = 0;
    n = 0;
    while (d1_set !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++;
    if (n != 8 || d1_money !== 10'd6) begin
      n_fail++; $display("FAIL timeout_restart: cycles=%0d money=%0d expected 8 6", n, d1_money);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (3) begin coin_c = 1; tick(); coin_c = 0; tick(); end
    n_checks++;
    if (d1_pending !== 10'd20 || d1_ovf !== 1'b1) begin
      n_fail++; $display("FAIL saturate: pending=%0d ovf=%0d expected 20 1", d1_pending, d1_ovf);
    end
    confirm = 1; tick(); confirm = 0;
    n_checks++;
    if (d1_set !== 1'b1 || d1_money !== 10'd20 || d1_ovf !== 1'b0) begin
      n_fail++; $display("FAIL sat_commit: set=%0d money=%0d ovf=%0d expected 1 20 0", d1_set, d1_money, d1_ovf);
    end
    coin_a = 1; tick(); coin_a = 0;
    n_checks++;
    if (d1_pending !== 10'd1 || d1_busy !== 1'b1 || d1_set !== 1'b0) begin
      n_fail++; $display("FAIL coin_in_commit: pending=%0d busy=%0d set=%0d expected 1 1 0", d1_pending, d1_busy, d1_set);
    end
  endtask

  task automatic test_idle_and_reset();
    do_reset();
    confirm = 1; tick(); confirm = 0; tick();
    cancel = 1; tick(); cancel = 0; tick();
    n_checks++;
    if (obs0 !== 34'h0) begin n_fail++; $display("FAIL idle_buttons: got %h expected 0", obs0); end
    coin_c = 1; tick(); coin_c = 0; tick();
    coin_b = 1; tick(); coin_b = 0; tick();
    n_checks++;
    if (d0_pending !== 10'd15) begin n_fail++; $display("FAIL pending_15: got %0d expected 15", d0_pending); end
    rst = 1;
    #2;
    model_reset();
    n_checks++;
    if (obs0 !== 34'h0 || obs1 !== 34'h0) begin
      n_fail++; $display("FAIL async_reset: got %h %h expected 0 0", obs0, obs1);
    end
    tick();
    rst = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_checks++;
      if (d0_set !== 1'b0 || d0_rv !== 1'b0 || d1_set !== 1'b0 || d1_rv !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_strobe: cycle %0d set=%0d/%0d rv=%0d/%0d expected 0",
                           k, d0_set, d1_set, d0_rv, d1_rv);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) coin_a = ~coin_a;
      if ($urandom_range(0, 4) == 0) coin_b = ~coin_b;
      if ($urandom_range(0, 5) == 0) coin_c = ~coin_c;
      confirm = ($urandom_range(0, 24) == 0);
      cancel  = ($urandom_range(0, 39) == 0);
      tick();
      n_checks++;
      if (obs0 !== exp_vec(0)) begin n_fail++; $display("FAIL random_dut0: cycle %0d got %h expected %h", k, obs0, exp_vec(0)); end
      n_checks++;
      if (obs1 !== exp_vec(1)) begin n_fail++; $display("FAIL random_dut1: cycle %0d got %h expected %h", k, obs1, exp_vec(1)); end
    end
    coin_a = 0; coin_b = 0; coin_c = 0; confirm = 0; cancel = 0;
  endtask

  initial begin
    rst = 1; coin_a = 1; coin_b = 0; coin_c = 0; confirm = 0; cancel = 0;
    model_reset();
    test_reset();
    test_confirm();
    test_simultaneous();
    test_timeout();
    test_saturation();
    test_idle_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
